// File: rtl/dc_sop_eval.sv
// Pipelined sum-of-products evaluator: N_TERMS programmable cubes with care masks over N_IN inputs,
// valid/ready on both sides and a saturating hit counter.
module dc_sop_eval #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic               cfg_en,
  input  logic               in_valid,
  input  logic [N_IN-1:0]    in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_y,
  output logic [N_TERMS-1:0] out_hits,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_count
);

  // Reset table makes term0 = A & B.
  localparam logic [N_IN-1:0] DefMask = N_IN'(3);

  logic [N_IN-1:0]    r_care [N_TERMS];
  logic [N_IN-1:0]    r_val  [N_TERMS];
  logic [N_TERMS-1:0] r_en;

  logic               r_s1_valid;
  logic [N_TERMS-1:0] r_s1_hits;
  logic               r_s2_valid;
  logic [N_TERMS-1:0] r_s2_hits;
  logic               r_s2_y;
  logic [CNT_W-1:0]   r_cnt;

  logic [N_TERMS-1:0] w_match;
  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_TERMS; t++) begin
        r_care[t] <= '0;
        r_val[t]  <= '0;
      end
      r_care[0] <= DefMask;
      r_val[0]  <= DefMask;
      r_en      <= N_TERMS'(1);
    end else if (cfg_we && (32'(cfg_idx) < N_TERMS)) begin
      r_care[cfg_idx] <= cfg_care;
      r_val[cfg_idx]  <= cfg_val;
      r_en[cfg_idx]   <= cfg_en;
    end
  end

  always_comb begin
    w_match = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      w_match[t] = r_en[t] & ~|((in_data ^ r_val[t]) & r_care[t]);
    end
  end

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = w_s2_adv | ~r_s1_valid;
  assign w_fire   = r_s2_valid & out_ready;

  // Match vector is computed at capture, so a same-edge table write never affects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hits  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      r_s1_hits  <= w_match;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_hits  <= '0;
      r_s2_y     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_hits  <= r_s1_hits;
      r_s2_y     <= |r_s1_hits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_fire && r_s2_y && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_y     = r_s2_y;
  assign out_hits  = r_s2_hits;
  assign hit_count = r_cnt;

endmodule
